// File: rtl/seg_pkg.sv
// Shared glyph constants and types for the 4-digit 7-segment scanner.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DIG_N  = 4;
  localparam int unsigned AN_W   = 4;
  localparam int unsigned SEG_W  = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [AN_W-1:0]  AN_OFF    = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Packed BCD word; element [i] is digit i (0 = ones).
  typedef logic [DIG_N-1:0][NIB_W-1:0] bcd_word_t;

endpackage

// File: rtl/bcd_seg_scanner_if.sv
// Load/enable inputs and display pin outputs of the scanner.
interface bcd_seg_scanner_if;

  seg_pkg::bcd_word_t bcd_in;
  logic               bcd_load;
  logic               enable;
  logic [3:0]         an;
  logic [6:0]         seg;
  logic               frame_done;

  modport master (
    output bcd_in, bcd_load, enable,
    input  an, seg, frame_done
  );

  modport slave (
    input  bcd_in, bcd_load, enable,
    output an, seg, frame_done
  );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational nibble to active-low 7-segment glyph; A-F render as a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (nib_i)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with a
// frame-coherent display register and leading-zero blanking.
module bcd_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  bcd_seg_scanner_if.slave   bus
);

  localparam int unsigned           CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_q, div_d;
  digit_idx_t       idx_q, idx_d;
  bcd_word_t        pend_q, pend_d;
  bcd_word_t        disp_q, disp_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             fd_q, fd_d;

  logic             tick_c;
  logic             boundary_c;
  logic [NIB_W-1:0] nib_c;
  logic [SEG_W-1:0] glyph_c;
  logic [DIG_N-1:0] upper_zero_c;
  logic             blank_c;

  assign tick_c     = bus.enable && (div_q == CNT_MAX);
  assign boundary_c = tick_c && (idx_q == digit_idx_t'(3));
  assign nib_c      = disp_q[idx_q];

  bcd_to_seg u_dec (
    .nib_i (nib_c),
    .seg_c (glyph_c)
  );

  // upper_zero_c[i]: digit i and every digit above it are zero
  always_comb begin
    upper_zero_c[3] = (disp_q[3] == '0);
    upper_zero_c[2] = upper_zero_c[3] && (disp_q[2] == '0);
    upper_zero_c[1] = upper_zero_c[2] && (disp_q[1] == '0);
    upper_zero_c[0] = upper_zero_c[1] && (disp_q[0] == '0);
  end

  assign blank_c = BLANK_LZ && (idx_q != digit_idx_t'(0)) && upper_zero_c[idx_q];

  always_comb begin
    div_d  = div_q;
    idx_d  = idx_q;
    pend_d = pend_q;
    disp_d = disp_q;
    fd_d   = 1'b0;
    an_d   = AN_OFF;
    seg_d  = SEG_BLANK;

    if (bus.bcd_load) begin
      pend_d = bus.bcd_in;
    end

    if (bus.enable) begin
      div_d = tick_c ? '0 : div_q + CNT_W'(1);
      an_d  = ~(AN_W'(1) << idx_q);
      seg_d = blank_c ? SEG_BLANK : glyph_c;
    end

    if (tick_c) begin
      idx_d = idx_q + digit_idx_t'(1);
    end

    // A load coinciding with the frame boundary bypasses the pending register
    if (boundary_c) begin
      disp_d = bus.bcd_load ? bus.bcd_in : pend_q;
      fd_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      disp_q <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
      fd_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Randomized bench for bcd_seg_scanner against a frame-position reference model,
// run on a blanking and a non-blanking instance in parallel.
module tb_bcd_seg_scanner;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bcd_seg_scanner_if bus_b ();
  bcd_seg_scanner_if bus_n ();

  bcd_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  bcd_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_n (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_n)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: position within the frame plus the shown and pending words
  int          m_phase;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg_b;
  logic [6:0]  e_seg_n;
  logic        e_fd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] digit_glyph(input logic [15:0] w, input int d, input bit blank);
    logic [15:0] upper;
    upper = w >> (4 * d);
    if (blank && d > 0 && upper == 16'd0) return 7'b1111111;
    return glyph_of(4'(upper));
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_disp  = 16'h0000;
    m_pend  = 16'h0000;
    e_an    = 4'b1111;
    e_seg_b = 7'b1111111;
    e_seg_n = 7'b1111111;
    e_fd    = 1'b0;
  endtask

  task automatic model_edge(input bit ld, input logic [15:0] v, input bit en);
    int d;
    bit bnd;
    logic [3:0] one;
    one = 4'b0001;
    d   = m_phase / DIV;
    bnd = en && (m_phase == FRAME - 1);
    e_an    = en ? ~(one << d) : 4'b1111;
    e_seg_b = en ? digit_glyph(m_disp, d, 1'b1) : 7'b1111111;
    e_seg_n = en ? digit_glyph(m_disp, d, 1'b0) : 7'b1111111;
    e_fd    = bnd;
    if (bnd) m_disp = ld ? v : m_pend;
    if (ld)  m_pend = v;
    if (en)  m_phase = (m_phase + 1) % FRAME;
  endtask

  task automatic drive(input bit ld, input logic [15:0] v, input bit en);
    bus_b.bcd_load = ld;
    bus_b.bcd_in   = v;
    bus_b.enable   = en;
    bus_n.bcd_load = ld;
    bus_n.bcd_in   = v;
    bus_n.enable   = en;
  endtask

  task automatic check_all();
    check_eq("an_b",  32'(bus_b.an),         32'(e_an));
    check_eq("seg_b", 32'(bus_b.seg),        32'(e_seg_b));
    check_eq("fd_b",  32'(bus_b.frame_done), 32'(e_fd));
    check_eq("an_n",  32'(bus_n.an),         32'(e_an));
    check_eq("seg_n", 32'(bus_n.seg),        32'(e_seg_n));
    check_eq("fd_n",  32'(bus_n.frame_done), 32'(e_fd));
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge
  task automatic step(input bit ld, input logic [15:0] v, input bit en);
    drive(ld, v, en);
    @(posedge clk);
    model_edge(ld, v, en);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic step_until_phase(input int p);
    for (int i = 0; i < FRAME && m_phase != p; i++) step(1'b0, 16'h0000, 1'b1);
    check_eq("reach_phase", 32'(m_phase), 32'(p));
  endtask

  logic [3:0] seq_an  [4];
  logic [6:0] seq_seg [4];

  initial begin
    int          hold;
    bit          en_r;
    logic [15:0] v;

    seq_an[0] = 4'b1110; seq_seg[0] = 7'b0011001;
    seq_an[1] = 4'b1101; seq_seg[1] = 7'b0110000;
    seq_an[2] = 4'b1011; seq_seg[2] = 7'b0100100;
    seq_an[3] = 4'b0111; seq_seg[3] = 7'b1111001;

    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // 0x1234 loaded exactly at a boundary: next frame is 4,3,2,1 each for DIV cycles
    run(3);
    step_until_phase(FRAME - 1);
    step(1'b1, 16'h1234, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      step(1'b0, 16'h0000, 1'b1);
      check_eq("f1234_an",  32'(bus_b.an),  32'(seq_an[k / DIV]));
      check_eq("f1234_seg", 32'(bus_b.seg), 32'(seq_seg[k / DIV]));
    end
    check_eq("f1234_fd", 32'(bus_b.frame_done), 32'd1);
    run(FRAME);

    // Leading-zero blanking and the all-zero word
    step(1'b1, 16'h0007, 1'b1);
    run(2 * FRAME);
    step(1'b1, 16'h0000, 1'b1);
    run(2 * FRAME);

    // Mid-frame load while digit 1 is active, then a load coinciding with a boundary
    step_until_phase(DIV);
    step(1'b1, 16'h5678, 1'b1);
    run(2 * FRAME);
    step(1'b1, 16'h1111, 1'b1);
    step_until_phase(FRAME - 1);
    step(1'b1, 16'h5678, 1'b1);
    run(FRAME);

    // Back-to-back loads within a frame: last one wins
    step(1'b1, 16'h2222, 1'b1);
    step(1'b1, 16'h3333, 1'b1);
    step(1'b1, 16'h0908, 1'b1);
    run(2 * FRAME);

    // Invalid digit renders as a dash and counts as nonzero
    step(1'b1, 16'h00A5, 1'b1);
    run(2 * FRAME);

    // Freeze with digit 2 shown and prescaler at 2, then resume
    step_until_phase(2 * DIV + 2);
    check_eq("pre_freeze_an", 32'(bus_b.an), 32'(4'b1011));
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b0);
    hold = 0;
    step(1'b0, 16'h0000, 1'b1);
    while (bus_b.an == 4'b1011 && hold < 20) begin
      hold++;
      step(1'b0, 16'h0000, 1'b1);
    end
    check_eq("resume_hold", 32'(hold), 32'd2);
    run(FRAME);

    // Asynchronous reset between edges; a pending load is discarded
    step_until_phase(5);
    step(1'b1, 16'h4321, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("areset_an_b",  32'(bus_b.an),         32'(4'b1111));
    check_eq("areset_seg_b", 32'(bus_b.seg),        32'(7'b1111111));
    check_eq("areset_fd_b",  32'(bus_b.frame_done), 32'd0);
    check_eq("areset_an_n",  32'(bus_n.an),         32'(4'b1111));
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;
    run(3 * FRAME);

    // Randomized loads, values and enable toggling
    en_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(29) == 0) en_r = ~en_r;
      if ($urandom_range(1) == 1) begin
        v = {4'($urandom_range(9)), 4'($urandom_range(9)),
             4'($urandom_range(9)), 4'($urandom_range(9))};
        v = v >> (4 * $urandom_range(3));
      end else begin
        v = 16'($urandom);
      end
      step($urandom_range(7) == 0, v, en_r);
    end
    run(FRAME);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scanner.md
Name: bcd_seg_scanner

Overview:
Time-multiplexed driver for a 4-digit, common-anode 7-segment display. It consumes the 16-bit packed BCD word produced by the binary-to-BCD converter, holds it in a frame-coherent display register, and scans the digits at a programmable refresh rate. Its outputs drive the board's anode and cathode pins directly. Leading-zero blanking and invalid-digit indication are included.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit stays lit (must be >= 2)
BLANK_LZ, 1, 1 = blank leading zeros on digits 3..1; 0 = always show all digits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
bcd_in  in  16  packed BCD: [3:0] = digit0 (ones), [15:12] = digit3 (thousands)
bcd_load  in  1  one-cycle strobe; capture bcd_in
enable  in  1  1 = scanning; 0 = display dark, scan frozen
an  out  4  anode enables, active-low, an[i] selects digit i
seg  out  7  cathodes, active-low, {g,f,e,d,c,b,a}
frame_done  out  1  one-cycle pulse at the end of each full 4-digit frame

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high.
- Reset values: an=4'b1111, seg=7'b1111111, frame_done=0. The prescaler, digit index, pending register and display register are all 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while enable=1.
  - tick=1 when count==REFRESH_DIV-1; the count then wraps to 0.
- Digit index:
  - 2-bit counter; advances on tick, 3 -> 0 wrap.
  - boundary = tick && index==3.
  - frame_done registered: equals 1 in the cycle after boundary, for one cycle.
- Load path:
  - On bcd_load, pending <= bcd_in.
  - On boundary, display <= (bcd_load ? bcd_in : pending). A load in the same cycle as the boundary takes effect immediately.
  - A load mid-frame never changes the frame in progress; there are no mixed-value frames.
  - Back-to-back loads within one frame: the last load wins.
- Decode:
  - Nibbles 0-9 use standard glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles A-F show a dash, 0111111.
- Blanking:
  - With BLANK_LZ=1, digit i (i=3..1) shows 1111111 when its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked; 0x0000 shows "0".
  - The anode of a blanked digit is still driven; only the cathodes are off.
- Output registration:
  - an and seg are registered from the current index and display.
  - Latency is one clk from an index change to the pins.
  - Exactly one an bit is low while enabled.
- enable=0:
  - Next edge: an=1111, seg=1111111.
  - Prescaler and index hold their values.
  - Loads are still accepted into pending; a boundary cannot occur.
  - Re-enable resumes on the held digit with the held count.
- Mid-operation reset: outputs go dark asynchronously and all state clears; any pending load is lost.

Decomposition:
- Package seg_pkg:
  - glyph constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
  - AN_OFF = 4'b1111
  - digit index typedef (2-bit)
- Sub-module bcd_to_seg: combinational nibble -> 7-bit active-low glyph, including the dash case. It is instantiated once and fed by a 4:1 nibble mux.
- The prescaler, index, load/shadow logic and blanking stay in the top module.

Test Plan:
- REFRESH_DIV=4, BLANK_LZ=1; reset, then load 0x1234 and wait for a boundary -> frame shows:
  - an=1110 with seg=0011001 ("4")
  - then 1101/0110000, 1011/0100100, 0111/1111001, each held 4 cycles
  - frame_done pulses every 16 cycles.
- Load 0x0007 -> digits 3..1 show an active with seg=1111111 and digit0 shows 1111000; then load 0x0000 -> digit0 shows 1000000, others blank. With BLANK_LZ=0, 0x0007 shows 1000000 on digits 3..1.
- Load 0x5678 while index==1 mid-frame, then compare with a load in the same cycle as boundary:
  - mid-frame load: digits 1-3 of that frame still show the old value; 0x5678 appears from the next digit0.
  - load at boundary: 0x5678 appears from the very next digit0.
- Load 0x00A5 -> digit1 shows 0111111, digit0 shows 0010010; the digit-1 dash counts as nonzero, so no blanking applies below digit 2.
- Deassert enable while an=1011 with prescaler count 2 for 10 cycles -> an=1111 and seg=1111111 throughout; re-enable -> an=1011 is driven for exactly 2 more cycles before advancing.
- Assert reset asynchronously between clk edges mid-scan -> an=1111 and seg=1111111 without waiting for a clock; after release the display stays blank-zero ("0" on digit0) until a new load.
